// File: rtl/io_cycle_pkg.sv
// Shared types and constants for the on-board I/O bus cycle controller.
package io_cycle_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_STROBE  = 3'd2,
      ST_ACK     = 3'd3,
      ST_ERR     = 3'd4,
      ST_RECOVER = 3'd5
   } state_e;

   localparam int TIMEOUT_CYC_DEF = 64;
   localparam int RECOVER_CYC_DEF = 2;

   typedef struct packed {
      logic rdio_n;
      logic wrio_n;
      logic cs5;
      logic cs7;
      logic dtack_n;
      logic berr_n;
      logic busy;
   } io_out_t;

   localparam io_out_t OUT_RST = '{rdio_n: 1'b1, wrio_n: 1'b1, cs5: 1'b0, cs7: 1'b0,
                                   dtack_n: 1'b1, berr_n: 1'b1, busy: 1'b0};

   // Smallest counter width able to hold both terminal counts.
   function automatic int cnt_w_min(input int timeout_cyc, input int recover_cyc);
      int m;
      m = (timeout_cyc > recover_cyc) ? timeout_cyc : recover_cyc;
      return $clog2(m + 1);
   endfunction

   // Output levels for the state being entered; flopped by the caller.
   function automatic io_out_t decode_out(input state_e st, input logic rw);
      io_out_t o;
      o      = OUT_RST;
      o.busy = (st != ST_IDLE);
      case (st)
         ST_SETUP: o.cs5 = 1'b1;
         ST_STROBE, ST_ACK: begin
            o.cs5     = 1'b1;
            o.cs7     = 1'b1;
            o.rdio_n  = ~rw;
            o.wrio_n  = rw;
            o.dtack_n = (st != ST_ACK);
         end
         ST_ERR: begin
            o.cs5    = 1'b1;
            o.berr_n = 1'b0;
         end
         default: ;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/io_cycle_ctl_if.sv
// CPU/ack-PAL side signals of the I/O cycle controller.
interface io_cycle_ctl_if;
   logic AS_n, RW, UDS_n, LDS_n, IOSEL, IOACK_n;
   logic RDIO_n, WRIO_n, CS5, CS7, DTACK_n, BERR_n, BUSY;

   modport master (
      output AS_n, RW, UDS_n, LDS_n, IOSEL, IOACK_n,
      input  RDIO_n, WRIO_n, CS5, CS7, DTACK_n, BERR_n, BUSY
   );

   modport slave (
      input  AS_n, RW, UDS_n, LDS_n, IOSEL, IOACK_n,
      output RDIO_n, WRIO_n, CS5, CS7, DTACK_n, BERR_n, BUSY
   );
endinterface

// File: rtl/io_cycle_counter.sv
// Saturating up-counter with sync clear; shared by the timeout and recovery counts.
module io_cycle_counter #(
   parameter int CNT_W = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] cmp,
   output logic             tc
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge CLK) begin
      if (RESET) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign tc = (cnt_q == cmp);

endmodule

// File: rtl/io_cycle_ctl.sv
// 68010 on-board I/O cycle controller: drives RDIO_n/WRIO_n/CS5/CS7 towards the
// ack PAL and turns IOACK_n into DTACK_n, or BERR_n on timeout.
module io_cycle_ctl import io_cycle_pkg::*; #(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int RECOVER_CYC = RECOVER_CYC_DEF,
   parameter int CNT_W       = 8
) (
   input  logic          CLK,
   input  logic          RESET,
   io_cycle_ctl_if.slave bus
);

   localparam int CW_MIN = cnt_w_min(TIMEOUT_CYC, RECOVER_CYC);
   localparam int CW     = (CNT_W > CW_MIN) ? CNT_W : CW_MIN;
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
   localparam logic [CW-1:0] RC_LAST = CW'(RECOVER_CYC - 1);

   state_e        state_q, state_d;
   logic          rw_q, rw_d;
   logic          start_q, start_d;
   io_out_t       out_q, out_d;
   logic          start_cond;
   logic          cnt_clr, cnt_en, cnt_tc;
   logic [CW-1:0] cnt_cmp;

   assign start_cond = !bus.AS_n && bus.IOSEL && (!bus.UDS_n || !bus.LDS_n);

   // The start is captured on the sampling edge and acted on one edge later,
   // so CS5 rises one edge after the start and the strobe one edge after that.
   always_comb begin
      state_d = state_q;
      rw_d    = rw_q;
      start_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_q) begin
               state_d = ST_SETUP;
            end else if (start_cond) begin
               start_d = 1'b1;
               rw_d    = bus.RW;
            end
         end
         ST_SETUP:   state_d = bus.AS_n ? ST_RECOVER : ST_STROBE;
         ST_STROBE: begin
            if (bus.AS_n)         state_d = ST_RECOVER;
            else if (!bus.IOACK_n) state_d = ST_ACK;
            else if (cnt_tc)      state_d = ST_ERR;
         end
         ST_ACK, ST_ERR: if (bus.AS_n) state_d = ST_RECOVER;
         ST_RECOVER:     if (cnt_tc)   state_d = ST_IDLE;
         default:        state_d = ST_IDLE;
      endcase

      cnt_clr = (state_d != state_q) && ((state_d == ST_STROBE) || (state_d == ST_RECOVER));
      cnt_en  = (state_q == ST_STROBE) || (state_q == ST_RECOVER);
      cnt_cmp = (state_q == ST_RECOVER) ? RC_LAST : TO_LAST;
      out_d   = decode_out(state_d, rw_q);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         rw_q    <= 1'b0;
         start_q <= 1'b0;
         out_q   <= OUT_RST;
      end else begin
         state_q <= state_d;
         rw_q    <= rw_d;
         start_q <= start_d;
         out_q   <= out_d;
      end
   end

   io_cycle_counter #(.CNT_W(CW)) u_cnt (
      .CLK   (CLK),
      .RESET (RESET),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .cmp   (cnt_cmp),
      .tc    (cnt_tc)
   );

   assign bus.RDIO_n  = out_q.rdio_n;
   assign bus.WRIO_n  = out_q.wrio_n;
   assign bus.CS5     = out_q.cs5;
   assign bus.CS7     = out_q.cs7;
   assign bus.DTACK_n = out_q.dtack_n;
   assign bus.BERR_n  = out_q.berr_n;
   assign bus.BUSY    = out_q.busy;

endmodule

// File: tb/tb_io_cycle_ctl.sv
// Randomised bus cycles; an edge-level cycle model fills a scoreboard that a
// separate monitor drains each time BUSY falls.
module tb_io_cycle_ctl;
   import io_cycle_pkg::*;

   localparam int T  = 64;
   localparam int RC = 2;

   typedef struct {
      int cs5_rise, str_fall, str_kind, str_len, cs7_len;
      int resp_kind, resp_edge, resp_len, cs5_len, busy_fall;
   } rec_t;

   logic CLK, RESET;
   int   edge_n = 0;
   int   ready_edge = 0;
   int   vectors = 0, miscompares = 0;
   rec_t exp_q[$];

   io_cycle_ctl_if bus();

   io_cycle_ctl #(.TIMEOUT_CYC(T), .RECOVER_CYC(RC), .CNT_W(8)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   always @(posedge CLK) edge_n <= edge_n + 1;

   task automatic chk(input string nm, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, req, edge_n);
      end
   endtask

   function automatic int outs();
      return int'({bus.RDIO_n, bus.WRIO_n, bus.CS5, bus.CS7, bus.DTACK_n, bus.BERR_n, bus.BUSY});
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Anything here lacks IOSEL or both data strobes, so it is never a start.
   task automatic drive_noise();
      bus.AS_n    = 1'($urandom);
      bus.RW      = 1'($urandom);
      bus.IOACK_n = 1'($urandom);
      if (($urandom % 2) == 0) begin
         bus.IOSEL = 1'b0; bus.UDS_n = 1'($urandom); bus.LDS_n = 1'($urandom);
      end else begin
         bus.IOSEL = 1'b1; bus.UDS_n = 1'b1; bus.LDS_n = 1'b1;
      end
   endtask

   // Edge-accurate outcome: e0 start edge, strobe at e0+2, IOACK first seen
   // low k edges after the strobe, AS_n seen high a edges after the strobe.
   function automatic rec_t model(input logic rw, input int k, input int a, input int e0);
      rec_t x;
      int   s, r;
      s = e0 + 2;
      r = s + a;
      x.cs5_rise = e0 + 1;
      x.str_fall = s;
      x.str_kind = rw ? 1 : 2;
      if (k < a && k <= T) begin
         x.resp_kind = 1; x.resp_edge = s + k; x.resp_len = a - k; x.str_len = a;
      end else if (T < a) begin
         x.resp_kind = 2; x.resp_edge = s + T; x.resp_len = a - T; x.str_len = T;
      end else begin
         x.resp_kind = 0; x.resp_edge = 0; x.resp_len = 0; x.str_len = a;
      end
      x.cs7_len   = x.str_len;
      x.cs5_len   = a + 1;
      x.busy_fall = r + RC;
      return x;
   endfunction

   task automatic run_tx(input logic rw, input logic [1:0] ds, input int k, input int w,
                         input int a, input int idle, input int rst_off);
      int   e0, s, r, nxt;
      rec_t x;
      repeat (idle) begin drive_noise(); step(); end
      e0 = (edge_n + 1 > ready_edge) ? edge_n + 1 : ready_edge;
      s  = e0 + 2;
      r  = s + a;
      bus.AS_n = 1'b0; bus.IOSEL = 1'b1; bus.UDS_n = ds[1]; bus.LDS_n = ds[0];
      bus.RW = rw; bus.IOACK_n = 1'b1;
      x = model(rw, k, a, e0);
      if (rst_off == 0) exp_q.push_back(x);
      while (1) begin
         step();
         nxt = edge_n + 1;
         if (rst_off > 0 && nxt == s + rst_off) begin
            chk("pre_rst_dtack", int'(bus.DTACK_n), 0);
            RESET = 1'b1;
            step();
            chk("rst_outs", outs(), 7'b1100110);
            RESET = 1'b0; bus.AS_n = 1'b1; bus.IOACK_n = 1'b1;
            ready_edge = edge_n + 1;
            return;
         end
         if (nxt > e0) bus.RW = 1'($urandom);
         bus.IOACK_n = !(nxt >= s + k && nxt < s + k + w);
         if (nxt == r) begin
            bus.AS_n = 1'b1;
            step();
            ready_edge = r + RC + 1;
            return;
         end
      end
   endtask

   // Monitor: rebuild each cycle from the pins, compare when BUSY drops.
   rec_t o, e;
   int   active = 0, cyc = 0, rd = 0, wr = 0;
   int   dt_len = 0, dt_edge = 0, be_len = 0, be_edge = 0;

   initial forever begin
      @(negedge CLK);
      if (RESET === 1'b1) begin
         active = 0;
      end else begin
         if (bus.BUSY === 1'b1 && active == 0) begin
            active = 1; cyc = 0; rd = 0; wr = 0;
            dt_len = 0; dt_edge = 0; be_len = 0; be_edge = 0;
            o = '{default: 0};
         end
         if (active != 0) begin
            cyc++;
            if (bus.CS5 === 1'b1) begin
               if (o.cs5_len == 0) o.cs5_rise = edge_n;
               o.cs5_len++;
            end
            if (bus.RDIO_n === 1'b0 || bus.WRIO_n === 1'b0) begin
               if (o.str_len == 0) o.str_fall = edge_n;
               o.str_len++;
            end
            if (bus.RDIO_n === 1'b0) rd = 1;
            if (bus.WRIO_n === 1'b0) wr = 1;
            if (bus.CS7 === 1'b1) o.cs7_len++;
            if (bus.DTACK_n === 1'b0) begin if (dt_len == 0) dt_edge = edge_n; dt_len++; end
            if (bus.BERR_n === 1'b0) begin if (be_len == 0) be_edge = edge_n; be_len++; end
            if (bus.BUSY !== 1'b1) begin
               o.busy_fall = edge_n;
               o.str_kind  = rd + 2 * wr;
               o.resp_kind = (dt_len > 0 ? 1 : 0) + (be_len > 0 ? 2 : 0);
               o.resp_edge = (dt_len > 0) ? dt_edge : be_edge;
               o.resp_len  = dt_len + be_len;
               if (exp_q.size() == 0) begin
                  chk("unexpected_cycle", o.cs5_rise, -1);
               end else begin
                  e = exp_q.pop_front();
                  chk("cs5_rise",  o.cs5_rise,  e.cs5_rise);
                  chk("str_fall",  o.str_fall,  e.str_fall);
                  chk("str_kind",  o.str_kind,  e.str_kind);
                  chk("str_len",   o.str_len,   e.str_len);
                  chk("cs7_len",   o.cs7_len,   e.cs7_len);
                  chk("resp_kind", o.resp_kind, e.resp_kind);
                  chk("resp_edge", o.resp_edge, e.resp_edge);
                  chk("resp_len",  o.resp_len,  e.resp_len);
                  chk("cs5_len",   o.cs5_len,   e.cs5_len);
                  chk("busy_fall", o.busy_fall, e.busy_fall);
               end
               active = 0;
            end else if (cyc > 1000) begin
               chk("busy_bound", cyc, 1000);
               active = 0;
            end
         end
      end
   end

   initial begin
      bus.AS_n = 1'b1; bus.RW = 1'b1; bus.UDS_n = 1'b1; bus.LDS_n = 1'b1;
      bus.IOSEL = 1'b0; bus.IOACK_n = 1'b1;
      RESET = 1'b1;
      repeat (3) step();
      chk("reset_outs", outs(), 7'b1100110);
      RESET = 1'b0;
      ready_edge = edge_n + 1;

      run_tx(1'b1, 2'b00, 3,    10, 8,     2, 0);  // read, DTACK at start+5
      run_tx(1'b0, 2'b10, 12,   20, 15,    0, 0);  // LDS-only write, held start
      run_tx(1'b1, 2'b01, 1000, 1,  T + 4, 1, 0);  // timeout
      run_tx(1'b0, 2'b00, T,    3,  T + 3, 1, 0);  // ack on the timeout edge
      run_tx(1'b0, 2'b00, 10,   4,  3,     1, 0);  // abort in strobe
      run_tx(1'b1, 2'b00, 1,    1,  4,     0, 0);  // start held in recovery, min cycle
      run_tx(1'b1, 2'b00, 2,    30, 20,    1, 5);  // reset while in ACK
      run_tx(1'b1, 2'b01, 2,    5,  5,     0, 0);  // read right after reset

      for (int n = 0; n < 40; n++) begin
         int k, a, w, idle;
         logic rw;
         logic [1:0] ds;
         rw = 1'($urandom);
         case ($urandom_range(2, 0))
            0:       ds = 2'b00;
            1:       ds = 2'b01;
            default: ds = 2'b10;
         endcase
         case ($urandom_range(3, 0))
            0, 1:    k = int'($urandom_range(12, 1));
            2:       k = int'($urandom_range(T + 4, 13));
            default: k = 1000;
         endcase
         w = int'($urandom_range(8, 1));
         if ($urandom_range(3, 0) == 0) a = int'($urandom_range(T + 10, 1));
         else if (k <= T)               a = k + int'($urandom_range(6, 1));
         else                           a = T + int'($urandom_range(6, 1));
         while (a == k || a == T) a++;
         idle = int'($urandom_range(4, 0));
         run_tx(rw, ds, k, w, a, idle, 0);
      end

      bus.AS_n = 1'b1; bus.IOACK_n = 1'b1;
      repeat (10) step();
      chk("drain", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
